iris_axil_mem_slave: RTL and testbench

//  AXI-Lite responder fronting a word-addressed 24-bit on-chip memory; the slave end of the per-core
//  AXI-Lite master port (AW/W/B write, AR/R read). One instance per core or behind the interconnect.

---
 rtl/iris_axil_pkg.sv | 19 +
 rtl/iris_sp_ram_1w1r.sv | 35 +++
 rtl/iris_axil_mem_slave.sv | 188 ++++++++++++++++++
 tb/tb_iris_axil_mem_slave.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iris_axil_pkg.sv
// Shared constants for the IRIS AXI-Lite memory slave: response codes, FSM encodings, lane count.
// Latency: n/a (constants only).
// Backpressure: n/a.
package iris_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam int BYTE_LANES = 3;

endpackage

// File: rtl/iris_sp_ram_1w1r.sv
// One-write one-read memory array with per-byte write enables and registered read data.
// Latency: read data valid one cycle after re; same-address read and write in one cycle return old data.
// Backpressure: none; rdata holds until the next re.
module iris_sp_ram_1w1r #(
    parameter int WORDS      = 4096,
    parameter int DATA_WIDTH = 24,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int IDX_W      = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LANES-1:0]      be,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/iris_axil_mem_slave.sv
// AXI-Lite slave over a word-addressed on-chip memory; IRIS_AXIL_WAIT_EN adds WAIT_CYCLES response delay.
// Latency: B two cycles after the last of AW/W, R one cycle after AR (plus WAIT_CYCLES when enabled).
// Backpressure: B/R held stable until bready/rready; AW/W/AR not accepted while a response is pending.
module iris_axil_mem_slave
    import iris_axil_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wlast,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast
);

    localparam int                    IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_WORDS - 1);

    logic [1:0]            w_state;
    logic [1:0]            r_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BYTE_LANES-1:0] w_strb_q;
    logic                  r_err_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_ok;

    logic aw_fire, w_fire, ar_fire, commit, wr_ok, rd_ok;

    assign axi_awready = (w_state == W_IDLE) && !aw_held;
    assign axi_wready  = (w_state == W_IDLE) && !w_held;
    assign axi_bvalid  = (w_state == W_RESP);
    assign axi_arready = (r_state == R_IDLE);
    assign axi_rvalid  = (r_state == R_RESP);
    assign axi_rlast   = (r_state == R_RESP);
    assign axi_rdata   = (axi_rvalid && !r_err_q) ? ram_rdata : '0;

    assign aw_fire = axi_awvalid && axi_awready;
    assign w_fire  = axi_wvalid && axi_wready;
    assign ar_fire = axi_arvalid && axi_arready;
    // Commit one cycle after both halves are captured; the flags block re-capture until B completes.
    assign commit  = (w_state == W_IDLE) && aw_held && w_held;
    assign wr_ok   = (aw_addr_q <= LAST_WORD);
    assign rd_ok   = (axi_araddr <= LAST_WORD);

`ifdef IRIS_AXIL_WAIT_EN
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    logic [3:0] w_cnt;
    logic [3:0] r_cnt;
    assign unused_ok = ^{axi_wstrb[3], axi_wlast};
`else
    assign unused_ok = ^{axi_wstrb[3], axi_wlast, WAIT_CYCLES[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            axi_bresp <= RESP_OKAY;
`ifdef IRIS_AXIL_WAIT_EN
            w_cnt     <= '0;
`endif
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= axi_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb[BYTE_LANES-1:0];
            end
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
`ifdef IRIS_AXIL_WAIT_EN
                        w_state   <= W_WAIT;
                        w_cnt     <= '0;
`else
                        w_state   <= W_RESP;
`endif
                    end
                end
`ifdef IRIS_AXIL_WAIT_EN
                W_WAIT: begin
                    if (w_cnt == WAIT_LAST) begin
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt + 4'd1;
                    end
                end
`endif
                W_RESP: begin
                    if (axi_bready) begin
                        w_state <= W_IDLE;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_err_q   <= 1'b0;
            axi_rresp <= RESP_OKAY;
`ifdef IRIS_AXIL_WAIT_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_err_q   <= !rd_ok;
                        axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
`ifdef IRIS_AXIL_WAIT_EN
                        r_state   <= R_WAIT;
                        r_cnt     <= '0;
`else
                        r_state   <= R_RESP;
`endif
                    end
                end
`ifdef IRIS_AXIL_WAIT_EN
                R_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
`endif
                R_RESP: begin
                    if (axi_rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    iris_sp_ram_1w1r #(
        .WORDS      (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (BYTE_LANES),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit && wr_ok),
        .be    (w_strb_q),
        .waddr (aw_addr_q[IDX_W-1:0]),
        .wdata (w_data_q),
        .re    (ar_fire && rd_ok),
        .raddr (axi_araddr[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_iris_axil_mem_slave.sv
// Randomized bench for iris_axil_mem_slave against a byte-lane memory model with known-byte tracking.
module tb_iris_axil_mem_slave;

    localparam int MW      = 4096;
    localparam int TB_WAIT = 3;
`ifdef IRIS_AXIL_WAIT_EN
    localparam int EXTRA = TB_WAIT;
`else
    localparam int EXTRA = 0;
`endif
    localparam int B_LAT = 2 + EXTRA;
    localparam int R_LAT = 1 + EXTRA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axi_awvalid, axi_awready;
    logic [15:0] axi_awaddr;
    logic        axi_wvalid, axi_wready;
    logic [23:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready;
    logic [15:0] axi_araddr;
    logic        axi_rvalid, axi_rready;
    logic [23:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] mdl   [MW];
    logic [2:0]  known [MW];

    always #5 clk = ~clk;

    iris_axil_mem_slave #(
        .DATA_WIDTH (24),
        .ADDR_WIDTH (16),
        .MEM_WORDS  (MW),
        .WAIT_CYCLES(TB_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_bresp   (axi_bresp),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_write(input logic [15:0] a, input logic [23:0] d, input logic [3:0] s);
        if (int'(a) < MW) begin
            for (int i = 0; i < 3; i++) begin
                if (s[i]) begin
                    mdl[a[11:0]][i*8 +: 8] = d[i*8 +: 8];
                    known[a[11:0]][i] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void exp_read(input logic [15:0] a, output logic [23:0] d,
                                     output logic [23:0] m, output logic [1:0] r);
        if (int'(a) >= MW) begin
            d = 24'h0;
            m = 24'hFFFFFF;
            r = 2'b10;
        end else begin
            d = mdl[a[11:0]];
            r = 2'b00;
            m = 24'h0;
            for (int i = 0; i < 3; i++) begin
                if (known[a[11:0]][i]) m[i*8 +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic wait_b(output int k);
        k = 0;
        do begin
            @(negedge clk);
            axi_awvalid = 1'b0;
            axi_wvalid  = 1'b0;
            k++;
        end while (!axi_bvalid && k < 64);
    endtask

    task automatic wait_r(output int k);
        k = 0;
        do begin
            @(negedge clk);
            axi_arvalid = 1'b0;
            k++;
        end while (!axi_rvalid && k < 64);
    endtask

    task automatic finish_b(input int hold, input logic [1:0] resp);
        bit stable = 1'b1;
        chk("bresp", axi_bresp, resp);
        repeat (hold) begin
            @(negedge clk);
            if (!axi_bvalid || axi_bresp !== resp) stable = 1'b0;
        end
        if (hold > 0) chk("b_stable", stable, 1'b1);
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        chk("b_drop", axi_bvalid, 1'b0);
        chk("aw_w_ready_after_b", {axi_awready, axi_wready}, 2'b11);
    endtask

    task automatic finish_r(input int hold, input logic [23:0] d, input logic [23:0] m, input logic [1:0] r);
        bit stable = 1'b1;
        logic [23:0] first;
        first = axi_rdata;
        chk("rdata", axi_rdata & m, d & m);
        chk("rresp", axi_rresp, r);
        chk("rlast", axi_rlast, 1'b1);
        repeat (hold) begin
            @(negedge clk);
            if (!axi_rvalid || !axi_rlast || axi_rdata !== first || axi_rresp !== r || axi_arready)
                stable = 1'b0;
        end
        if (hold > 0) chk("r_stable_arready_low", stable, 1'b1);
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        chk("r_drop", {axi_rvalid, axi_rlast, axi_arready}, 3'b001);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [23:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold);
        int t = 0;
        int k;
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        while (!(aw_done && w_done) && t < 64) begin
            @(negedge clk);
            if (w_done && !aw_done) chk("wready_low_after_w", axi_wready, 1'b0);
            if (aw_done && !w_done) chk("awready_low_after_aw", axi_awready, 1'b0);
            axi_awvalid = !aw_done && (t >= aw_dly);
            axi_awaddr  = a;
            axi_wvalid  = !w_done && (t >= w_dly);
            axi_wdata   = d;
            axi_wstrb   = s;
            if (axi_awvalid && axi_awready) aw_done = 1'b1;
            if (axi_wvalid && axi_wready) w_done = 1'b1;
            t++;
        end
        chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
        wait_b(k);
        chk("b_latency", k, B_LAT);
        mdl_write(a, d, s);
        finish_b(hold, (int'(a) < MW) ? 2'b00 : 2'b10);
    endtask

    task automatic do_read(input logic [15:0] a, input int hold);
        int k;
        logic [23:0] d, m;
        logic [1:0] r;
        @(negedge clk);
        axi_arvalid = 1'b1;
        axi_araddr  = a;
        chk("arready_idle", axi_arready, 1'b1);
        wait_r(k);
        chk("r_latency", k, R_LAT);
        exp_read(a, d, m, r);
        finish_r(hold, d, m, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [23:0] d, m;
        logic [1:0] r;
        logic [15:0] wa, ra;

        for (int i = 0; i < MW; i++) begin
            known[i] = 3'b000;
            mdl[i]   = 24'h0;
        end
        rst_n = 1'b0;
        axi_awvalid = 1'b0; axi_awaddr = '0;
        axi_wvalid = 1'b0;  axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b1;
        axi_bready = 1'b0;
        axi_arvalid = 1'b0; axi_araddr = '0;
        axi_rready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_bvalid", axi_bvalid, 1'b0);
        chk("rst_rvalid_rlast", {axi_rvalid, axi_rlast}, 2'b00);
        chk("rst_resp", {axi_bresp, axi_rresp}, 4'b0000);
        chk("rst_rdata", axi_rdata, 24'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);

        // Directed cases.
        do_write(16'h0010, 24'h123456, 4'b0111, 0, 0, 0);
        do_read(16'h0010, 0);
        do_write(16'h0020, 24'hABCDEF, 4'b0111, 2, 0, 0);
        do_read(16'h0020, 0);
        do_write(16'h0010, 24'hFFFFFF, 4'b0010, 0, 0, 0);
        do_read(16'h0010, 0);
        do_write(16'h0010, 24'h000000, 4'b1000, 0, 0, 0);
        do_read(16'h0010, 0);
        do_write(16'h0000, 24'h0A0B0C, 4'b0111, 0, 1, 0);
        do_write(16'(MW), 24'h555555, 4'b0111, 0, 0, 0);
        do_read(16'(MW), 0);
        do_read(16'hFFFF, 0);
        do_read(16'h0000, 0);
        do_write(16'h0030, 24'h5A5A5A, 4'b0111, 0, 0, 5);
        do_read(16'h0030, 5);

        // Same-cycle write commit and AR to the same word must return the old data.
        do_write(16'h0040, 24'h111111, 4'b0111, 0, 0, 0);
        @(negedge clk);
        axi_awvalid = 1'b1; axi_awaddr = 16'h0040;
        axi_wvalid = 1'b1;  axi_wdata = 24'h222222; axi_wstrb = 4'b0111;
        chk("rbw_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_arvalid = 1'b1; axi_araddr = 16'h0040;
        wait_r(k);
        chk("rbw_r_latency", k, R_LAT);
        exp_read(16'h0040, d, m, r);
        finish_r(0, d, m, r);
        mdl_write(16'h0040, 24'h222222, 4'b0111);
        wait_b(k);
        finish_b(0, 2'b00);
        do_read(16'h0040, 0);

        // Reset with B and R pending.
        @(negedge clk);
        axi_awvalid = 1'b1; axi_awaddr = 16'h0050;
        axi_wvalid = 1'b1;  axi_wdata = 24'h777777; axi_wstrb = 4'b0111;
        wait_b(k);
        chk("rst_mid_b_latency", k, B_LAT);
        mdl_write(16'h0050, 24'h777777, 4'b0111);
        axi_arvalid = 1'b1; axi_araddr = 16'h0050;
        wait_r(k);
        chk("rst_mid_r_latency", k, R_LAT);
        chk("rst_mid_both_valid", {axi_bvalid, axi_rvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {axi_bvalid, axi_rvalid, axi_rlast}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
        do_read(16'h0050, 0);

        // Randomized mix of writes, reads and concurrent write+read.
        for (int it = 0; it < 80; it++) begin
            int sel, op;
            sel = $urandom_range(0, 9);
            if (sel == 0)      wa = 16'(MW + $urandom_range(0, 100));
            else if (sel == 1) wa = 16'hFFFF;
            else               wa = 16'($urandom_range(0, 15));
            ra = wa ^ 16'h0001;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(wa, 24'($urandom), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op == 1) begin
                do_read(wa, $urandom_range(0, 3));
            end else begin
                fork
                    do_write(wa, 24'($urandom), 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                    do_read(ra, $urandom_range(0, 3));
                join
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
